sam_pool: RTL and testbench

- Streaming 1-D max-pool with optional ReLU. Sits directly downstream of SAM_Con and consumes its 32-bit signed Data_Out / Last_Data_Out stream.
- Emits one pooled word per completed window and propagates the frame-end marker.
- Supports overlapping windows (stride < size) and flushes a partial window when the frame ends.
- No backpressure: one input word per cycle maximum, one output word per cycle maximum.

---
 rtl/sam_pkg.sv | 16 +
 rtl/sam_pool_if.sv | 22 ++
 rtl/sam_max_tree.sv | 21 ++
 rtl/sam_pool.sv | 105 ++++++++++
 tb/tb_sam_pool.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/sam_pkg.sv
// Shared types and helpers for the SAM streaming datapath.
// Holds the sample width, the signed sample type and the ReLU helper.
package sam_pkg;

    localparam int DATA_W = 32;

    typedef logic signed [DATA_W-1:0] sam_data_t;

    // Most-negative sample; identity element for a signed max.
    localparam sam_data_t SAM_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic sam_data_t sam_relu(input sam_data_t value);
        return value[DATA_W-1] ? sam_data_t'({DATA_W{1'b0}}) : value;
    endfunction

endpackage

// File: rtl/sam_pool_if.sv
// Sample stream into and pooled stream out of sam_pool.
// The master drives samples and observes pooled results; the slave is the pool.
interface sam_pool_if;
    import sam_pkg::*;

    sam_data_t Data_in;
    logic      Valid_In;
    logic      Last_Data_In;
    sam_data_t Data_Out;
    logic      Valid_Out;
    logic      Last_Data_Out;

    modport master (
        output Data_in, Valid_In, Last_Data_In,
        input  Data_Out, Valid_Out, Last_Data_Out
    );

    modport slave (
        input  Data_in, Valid_In, Last_Data_In,
        output Data_Out, Valid_Out, Last_Data_Out
    );
endinterface

// File: rtl/sam_max_tree.sv
// Combinational signed maximum over N lanes.
// Disabled lanes contribute the most-negative value, so they never win.
module sam_max_tree
    import sam_pkg::*;
#(
    parameter int N = 2
) (
    input  sam_data_t      data [N],
    input  logic [N-1:0]   en,
    output sam_data_t      max_val
);

    // Running signed maximum across the enabled lanes
    always_comb begin
        max_val = SAM_MIN;
        for (int i = 0; i < N; i++) begin
            max_val = (en[i] && (data[i] > max_val)) ? data[i] : max_val;
        end
    end

endmodule

// File: rtl/sam_pool.sv
// Streaming 1-D max-pool with optional ReLU and partial-window flush at frame end.
// One-cycle latency: the result is registered on the edge accepting the completing sample.
module sam_pool
    import sam_pkg::*;
#(
    parameter int POOL_SIZE   = 2,
    parameter int POOL_STRIDE = 2,
    parameter bit RELU_EN     = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    sam_pool_if.slave   bus
);

    localparam int FILL_W = $clog2(POOL_SIZE + 1);

    if ((POOL_SIZE < 1) || (POOL_SIZE > 8) || (POOL_STRIDE < 1) || (POOL_STRIDE > POOL_SIZE)) begin : g_param_check
        $error("sam_pool: need 1 <= POOL_STRIDE <= POOL_SIZE <= 8");
    end

    sam_data_t              win_buf_r [POOL_SIZE];
    logic [FILL_W-1:0]      fill_r;
    sam_data_t              data_out_r;
    logic                   valid_out_r;
    logic                   last_out_r;

    sam_data_t              lane_s [POOL_SIZE];
    logic [POOL_SIZE-1:0]   lane_en_s;
    logic [FILL_W-1:0]      fill_n_s;
    logic                   emit_s;
    logic                   fire_s;
    sam_data_t              max_s;
    sam_data_t              result_s;

    // Window view: lane 0 is the incoming sample, lane i the sample i steps older
    always_comb begin
        fill_n_s = fill_r + FILL_W'(1);
        lane_s[0] = bus.Data_in;
        for (int i = 1; i < POOL_SIZE; i++) begin
            lane_s[i] = win_buf_r[i-1];
        end
        for (int i = 0; i < POOL_SIZE; i++) begin
            lane_en_s[i] = (FILL_W'(i) < fill_n_s);
        end
    end

    sam_max_tree #(
        .N       (POOL_SIZE)
    ) u_max_tree (
        .data    (lane_s),
        .en      (lane_en_s),
        .max_val (max_s)
    );

    // A full window emits; a frame end emits whatever partial window is held
    always_comb begin
        emit_s = (fill_n_s == FILL_W'(POOL_SIZE));
        fire_s = emit_s || bus.Last_Data_In;
        if (RELU_EN) begin
            result_s = sam_relu(max_s);
        end else begin
            result_s = max_s;
        end
    end

    // Window buffer, fill count and registered outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < POOL_SIZE; i++) begin
                win_buf_r[i] <= {DATA_W{1'b0}};
            end
            fill_r      <= {FILL_W{1'b0}};
            data_out_r  <= {DATA_W{1'b0}};
            valid_out_r <= 1'b0;
            last_out_r  <= 1'b0;
        end else if (bus.Valid_In) begin
            win_buf_r[0] <= bus.Data_in;
            for (int i = 1; i < POOL_SIZE; i++) begin
                win_buf_r[i] <= win_buf_r[i-1];
            end
            if (bus.Last_Data_In) begin
                fill_r <= {FILL_W{1'b0}};
            end else if (emit_s) begin
                fill_r <= FILL_W'(POOL_SIZE - POOL_STRIDE);
            end else begin
                fill_r <= fill_n_s;
            end
            if (fire_s) begin
                data_out_r <= result_s;
            end else begin
                data_out_r <= data_out_r;
            end
            valid_out_r <= fire_s;
            last_out_r  <= bus.Last_Data_In;
        end else begin
            valid_out_r <= 1'b0;
            last_out_r  <= 1'b0;
        end
    end

    assign bus.Data_Out      = data_out_r;
    assign bus.Valid_Out     = valid_out_r;
    assign bus.Last_Data_Out = last_out_r;

endmodule

// File: tb/tb_sam_pool.sv
// Scoreboard bench for sam_pool: four configurations share one input stream,
// expected outputs come from a frame-index reference model, a monitor compares.
module tb_sam_pool;
    import sam_pkg::*;

    localparam int NI = 4;
    localparam int SZ [NI] = '{2, 2, 3, 4};
    localparam int ST [NI] = '{2, 1, 2, 3};
    localparam bit RL [NI] = '{1'b1, 1'b1, 1'b0, 1'b0};

    typedef struct {
        sam_data_t data;
        logic      last;
    } exp_t;

    logic      Clk = 1'b0;
    logic      Rst = 1'b1;
    sam_data_t din = 32'sd0;
    logic      vin = 1'b0;
    logic      lin = 1'b0;

    sam_data_t dout [NI];
    logic      vout [NI];
    logic      lout [NI];

    exp_t      exp_q [NI][$];
    sam_data_t held [NI];
    sam_data_t frame [$];
    int        total = 0;
    int        passed = 0;

    always #5 Clk = ~Clk;

    sam_pool_if ifc0 ();
    sam_pool_if ifc1 ();
    sam_pool_if ifc2 ();
    sam_pool_if ifc3 ();

    assign ifc0.Data_in = din; assign ifc0.Valid_In = vin; assign ifc0.Last_Data_In = lin;
    assign ifc1.Data_in = din; assign ifc1.Valid_In = vin; assign ifc1.Last_Data_In = lin;
    assign ifc2.Data_in = din; assign ifc2.Valid_In = vin; assign ifc2.Last_Data_In = lin;
    assign ifc3.Data_in = din; assign ifc3.Valid_In = vin; assign ifc3.Last_Data_In = lin;

    assign dout[0] = ifc0.Data_Out; assign vout[0] = ifc0.Valid_Out; assign lout[0] = ifc0.Last_Data_Out;
    assign dout[1] = ifc1.Data_Out; assign vout[1] = ifc1.Valid_Out; assign lout[1] = ifc1.Last_Data_Out;
    assign dout[2] = ifc2.Data_Out; assign vout[2] = ifc2.Valid_Out; assign lout[2] = ifc2.Last_Data_Out;
    assign dout[3] = ifc3.Data_Out; assign vout[3] = ifc3.Valid_Out; assign lout[3] = ifc3.Last_Data_Out;

    sam_pool #(.POOL_SIZE(2), .POOL_STRIDE(2), .RELU_EN(1'b1)) u_dut0 (.Clk(Clk), .Rst(Rst), .bus(ifc0));
    sam_pool #(.POOL_SIZE(2), .POOL_STRIDE(1), .RELU_EN(1'b1)) u_dut1 (.Clk(Clk), .Rst(Rst), .bus(ifc1));
    sam_pool #(.POOL_SIZE(3), .POOL_STRIDE(2), .RELU_EN(1'b0)) u_dut2 (.Clk(Clk), .Rst(Rst), .bus(ifc2));
    sam_pool #(.POOL_SIZE(4), .POOL_STRIDE(3), .RELU_EN(1'b0)) u_dut3 (.Clk(Clk), .Rst(Rst), .bus(ifc3));

    // Max of the newest n samples of the current frame
    function automatic sam_data_t frame_max(input int n);
        sam_data_t m;
        m = frame[frame.size()-1];
        for (int j = frame.size() - n; j < frame.size(); j++) begin
            if (frame[j] > m) m = frame[j];
        end
        return m;
    endfunction

    // Windows start at multiples of the stride within a frame; a frame end
    // flushes the samples gathered since the latest window start.
    task automatic send(input sam_data_t d, input logic last);
        int p;
        int n;
        sam_data_t v;
        din = d;
        vin = 1'b1;
        lin = last;
        frame.push_back(d);
        p = frame.size();
        for (int k = 0; k < NI; k++) begin
            n = 0;
            if ((p >= SZ[k]) && (((p - SZ[k]) % ST[k]) == 0)) n = SZ[k];
            else if (last) n = (p < SZ[k]) ? p : (SZ[k] - ST[k] + ((p - SZ[k]) % ST[k]));
            if (n > 0) begin
                v = frame_max(n);
                if (RL[k] && (v < 0)) v = 32'sd0;
                exp_q[k].push_back('{v, last});
            end
        end
        if (last) frame.delete();
        @(posedge Clk);
        #1;
        vin = 1'b0;
        din = sam_data_t'($urandom);
        lin = 1'($urandom);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            din = sam_data_t'($urandom);
            lin = 1'($urandom);
            @(posedge Clk);
            #1;
        end
    endtask

    function automatic sam_data_t pick_data();
        case ($urandom_range(0, 3))
            0: return sam_data_t'($urandom_range(0, 100)) - 32'sd50;
            1: return sam_data_t'($urandom);
            2: return ($urandom_range(0, 1) == 0) ? 32'sh8000_0000 : 32'sh7fff_ffff;
            default: return -sam_data_t'($urandom_range(1, 1000));
        endcase
    endfunction

    // Monitor: compare every presented result against the scoreboard, and
    // check quiet/hold behaviour when nothing is presented
    always @(negedge Clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            total++;
            if (Rst) begin
                held[k] = 32'sd0;
                if ((dout[k] !== 32'sd0) || (vout[k] !== 1'b0) || (lout[k] !== 1'b0))
                    $display("FAIL reset_out%0d: got data=%0d valid=%0b last=%0b, want all 0", k, dout[k], vout[k], lout[k]);
                else passed++;
            end else if (vout[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    $display("FAIL unexpected_out%0d: got data=%0d last=%0b, want no output", k, dout[k], lout[k]);
                end else begin
                    e = exp_q[k].pop_front();
                    held[k] = e.data;
                    if ((dout[k] !== e.data) || (lout[k] !== e.last))
                        $display("FAIL result_out%0d: got data=%0d last=%0b, want data=%0d last=%0b", k, dout[k], lout[k], e.data, e.last);
                    else passed++;
                end
            end else begin
                if ((vout[k] !== 1'b0) || (lout[k] !== 1'b0) || (dout[k] !== held[k]))
                    $display("FAIL idle_out%0d: got data=%0d valid=%0b last=%0b, want data=%0d valid=0 last=0", k, dout[k], vout[k], lout[k], held[k]);
                else passed++;
            end
        end
    end

    initial begin
        sam_data_t f1 [5] = '{32'sd3, -32'sd7, 32'sd9, 32'sd2, -32'sd4};
        int len;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        idle(2);

        for (int i = 0; i < 16; i++) send(sam_data_t'(i), (i == 15));
        idle(2);

        for (int i = 0; i < 5; i++) send(f1[i], (i == 4));
        idle(2);

        send(-32'sd5, 1'b0);
        send(-32'sd2, 1'b0);
        send(-32'sd8, 1'b1);
        send(32'sd10, 1'b0);
        idle(3);
        send(32'sd20, 1'b0);
        send(32'sd30, 1'b0);
        idle(1);
        send(32'sd40, 1'b1);
        idle(2);

        send(32'sd7, 1'b0);
        Rst = 1'b1;
        frame.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        send(32'sd1, 1'b0);
        send(32'sd2, 1'b1);
        idle(2);

        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send(pick_data(), (j == len - 1));
            end
            idle($urandom_range(0, 1));
        end

        idle(4);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (exp_q[k].size() != 0)
                $display("FAIL drained_out%0d: got %0d results still pending, want 0", k, exp_q[k].size());
            else passed++;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
